// File: rtl/hit_write_arbiter_if.sv
// Bus bundle for hit_write_arbiter: hit inputs, memory write port, status.
// HIT_DROP_COUNT_EN adds the drop_count status signal.
interface hit_write_arbiter_if;
  logic [3:0]  hit_req;
  logic [15:0] pkt_num;
  logic [31:0] base_addr;
  logic [7:0]  depth;
  logic        wait_req;
  logic        clr_ovf;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  ovf;
  logic        busy;
`ifdef HIT_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  modport slave (
    input  hit_req, pkt_num, base_addr, depth,
    input  wait_req, clr_ovf,
    output mem_addr, mem_write, mem_wdata,
    output ovf, busy
`ifdef HIT_DROP_COUNT_EN
    , output drop_count
`endif
  );

  modport master (
    output hit_req, pkt_num, base_addr, depth,
    output wait_req, clr_ovf,
    input  mem_addr, mem_write, mem_wdata,
    input  ovf, busy
`ifdef HIT_DROP_COUNT_EN
    , input drop_count
`endif
  );
endinterface

// File: rtl/hit_write_arbiter.sv
// Round-robin arbiter writing 4-source hit records into a ring of result slots.
// Optional HIT_DROP_COUNT_EN adds a saturating dropped-hit counter.
module hit_write_arbiter (
  input logic                 clk,
  input logic                 rst,
  hit_write_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, WRITE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  slot_q, slot_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  ovf_q, ovf_d;
  logic [15:0] cap_q [4];
  logic [15:0] cap_d [4];

  logic        accept;
  logic [3:0]  clr_mask;
  logic [3:0]  drop;
  logic [3:0]  take;
  logic [1:0]  gnt;
  logic [1:0]  idx;
  logic        found;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    slot_d   = slot_q;
    cap_d    = cap_q;
    accept   = (state_q == WRITE) && !bus.wait_req;
    clr_mask = accept ? (4'b0001 << grant_q) : 4'b0000;
    // a pulse landing on the acceptance cycle refills the slot instead of dropping
    drop     = bus.hit_req & pend_q & ~clr_mask;
    take     = bus.hit_req & ~drop;
    pend_d   = (pend_q & ~clr_mask) | take;
    ovf_d    = (bus.clr_ovf ? 4'b0000 : ovf_q) | drop;
    for (int i = 0; i < 4; i++) begin
      if (take[i]) cap_d[i] = bus.pkt_num;
    end

    gnt   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          grant_d = gnt;
          ptr_d   = gnt + 2'd1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          slot_d  = (slot_q == bus.depth - 8'd1) ? 8'd0 : slot_q + 8'd1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      grant_q <= 2'd0;
      slot_q  <= 8'd0;
      pend_q  <= 4'd0;
      ovf_q   <= 4'd0;
      for (int i = 0; i < 4; i++) cap_q[i] <= 16'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      slot_q  <= slot_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      cap_q   <= cap_d;
    end
  end

  // outputs decode straight from state so reset drops mem_write at once
  assign bus.mem_write = (state_q == WRITE);
  assign bus.mem_addr  = bus.mem_write
                       ? bus.base_addr + {22'd0, slot_q, 2'b00}
                       : 32'd0;
  assign bus.mem_wdata = bus.mem_write
                       ? {grant_q, 14'd0, cap_q[grant_q]}
                       : 32'd0;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (|pend_q) || (state_q == WRITE);

`ifdef HIT_DROP_COUNT_EN
  logic [15:0] dc_q, dc_d, dc_base;
  logic [2:0]  ndrop;
  logic [16:0] dc_sum;

  always_comb begin
    ndrop   = 3'($countones(drop));
    dc_base = bus.clr_ovf ? 16'd0 : dc_q;
    dc_sum  = {1'b0, dc_base} + 17'(ndrop);
    dc_d    = dc_sum[16] ? 16'hFFFF : dc_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dc_q <= 16'd0;
    else     dc_q <= dc_d;
  end

  assign bus.drop_count = dc_q;
`endif
endmodule

// File: tb/tb_hit_write_arbiter.sv
// Scoreboard bench for hit_write_arbiter: directed scenarios then random traffic.
// Reference model tracks pending hits per source and predicts each record.
module tb_hit_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  hit_write_arbiter_if bus();

  hit_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  int checks = 0;
  int errors = 0;

  rec_t exp_q[$];
  rec_t seen[$];

  bit          m_pend [4];
  logic [15:0] m_cap  [4];
  int          m_ptr, m_slot, m_g, m_dc;
  bit          m_wr;
  logic [3:0]  m_ovf;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 1'b0;
      m_cap[i]  = 16'd0;
    end
    m_ptr = 0; m_slot = 0; m_g = 0; m_dc = 0;
    m_wr = 1'b0;
    m_ovf = 4'd0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit         acc, any;
    bit         old_p [4];
    logic [3:0] h, dm;
    int         drops, dn, pick;
    rec_t       r;
    h = bus.hit_req;
    dm = 4'd0;
    drops = 0;
    any = 1'b0;
    acc = m_wr && !bus.wait_req;
    dn = (bus.depth == 8'd0) ? 256 : int'(bus.depth);
    for (int i = 0; i < 4; i++) begin
      old_p[i] = m_pend[i];
      if (m_pend[i]) any = 1'b1;
    end
    if (acc) m_pend[m_g] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (h[i]) begin
        if (m_pend[i]) begin
          dm[i] = 1'b1;
          drops++;
        end else begin
          m_pend[i] = 1'b1;
          m_cap[i]  = bus.pkt_num;
        end
      end
    end
    m_ovf = (bus.clr_ovf ? 4'd0 : m_ovf) | dm;
    m_dc = (bus.clr_ovf ? 0 : m_dc) + drops;
    if (m_dc > 65535) m_dc = 65535;
    if (acc) begin
      m_wr = 1'b0;
      m_slot = (m_slot + 1) % dn;
    end else if (!m_wr && any) begin
      pick = -1;
      for (int k = 0; k < 4; k++) begin
        if (pick < 0 && old_p[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
      end
      m_g = pick;
      m_ptr = (pick + 1) % 4;
      m_wr = 1'b1;
      r.addr = bus.base_addr + 32'(4 * m_slot);
      r.data = (32'(pick) << 30) | 32'(m_cap[pick]);
      exp_q.push_back(r);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // monitor: lockstep status checks, record pops on every accepted write
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
      end else begin
        chk("mem_write", 32'(bus.mem_write), 32'(m_wr));
        chk("busy", 32'(bus.busy),
            32'(m_wr || m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3]));
        chk("ovf", 32'(bus.ovf), 32'(m_ovf));
`ifdef HIT_DROP_COUNT_EN
        chk("drop_count", 32'(bus.drop_count), 32'(m_dc));
`endif
        if (bus.mem_write && !bus.wait_req) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", bus.mem_addr, 32'hFFFF_FFFF);
          end else begin
            r = exp_q.pop_front();
            chk("rec_addr", bus.mem_addr, r.addr);
            chk("rec_data", bus.mem_wdata, r.data);
          end
          r.addr = bus.mem_addr;
          r.data = bus.mem_wdata;
          seen.push_back(r);
        end
      end
    end
  end

  task automatic cyc(logic [3:0] h, logic [15:0] p, logic w, logic c);
    bus.hit_req  = h;
    bus.pkt_num  = p;
    bus.wait_req = w;
    bus.clr_ovf  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (bus.busy && n < 60) begin
      cyc(4'd0, 16'd0, 1'b0, 1'b0);
      n++;
    end
    chk("drain_timeout", 32'(n < 60), 32'd1);
  endtask

  task automatic do_reset(logic [31:0] b, logic [7:0] d);
    bus.hit_req = 4'd0;
    bus.wait_req = 1'b0;
    bus.clr_ovf = 1'b0;
    rst = 1'b1;
    bus.base_addr = b;
    bus.depth = d;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen.delete();
  endtask

  logic [31:0] d32 [4];

  initial begin
    bus.hit_req = 4'd0;
    bus.pkt_num = 16'd0;
    bus.base_addr = 32'd0;
    bus.depth = 8'd4;
    bus.wait_req = 1'b0;
    bus.clr_ovf = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // single hit, latency 2
    do_reset(32'h1000, 8'd4);
    cyc(4'b0100, 16'h0033, 1'b0, 1'b0);
    chk("lat_cycle1", 32'(bus.mem_write), 32'd0);
    cyc(4'b0000, 16'h0000, 1'b0, 1'b0);
    chk("lat_cycle2", 32'(bus.mem_write), 32'd1);
    chk("single_addr", bus.mem_addr, 32'h1000);
    chk("single_data", bus.mem_wdata, 32'h8000_0033);
    drain();
    chk("single_count", 32'(seen.size()), 32'd1);

    // all four at once, round-robin order
    do_reset(32'h100, 8'd4);
    cyc(4'b1111, 16'h0007, 1'b0, 1'b0);
    drain();
    d32 = '{32'h0000_0007, 32'h4000_0007, 32'h8000_0007, 32'hC000_0007};
    chk("rr_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      chk("rr_data", seen[i].data, d32[i]);
      chk("rr_addr", seen[i].addr, 32'h100 + 32'(4 * i));
    end
    cyc(4'b1001, 16'h0009, 1'b0, 1'b0);
    drain();
    chk("rr_ptr_count", 32'(seen.size()), 32'd6);
    if (seen.size() >= 6) begin
      chk("rr_ptr0_data", seen[4].data, 32'h0000_0009);
      chk("rr_ptr0_addr", seen[4].addr, 32'h100);
      chk("rr_ptr1_data", seen[5].data, 32'hC000_0009);
    end

    // stall with drop, then clear
    do_reset(32'h2000, 8'd4);
    cyc(4'b0001, 16'h0011, 1'b0, 1'b0);
    cyc(4'b0000, 16'h0000, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc((k == 1) ? 4'b0001 : 4'b0000, 16'h0022, 1'b1, 1'b0);
      chk("stall_write", 32'(bus.mem_write), 32'd1);
      chk("stall_addr", bus.mem_addr, 32'h2000);
      chk("stall_data", bus.mem_wdata, 32'h0000_0011);
    end
    drain();
    chk("stall_ovf", 32'(bus.ovf), 32'h1);
    chk("stall_count", 32'(seen.size()), 32'd1);
`ifdef HIT_DROP_COUNT_EN
    chk("stall_drop_count", 32'(bus.drop_count), 32'd1);
`endif
    cyc(4'b0000, 16'h0000, 1'b0, 1'b1);
    chk("clr_ovf", 32'(bus.ovf), 32'h0);

    // slot wrap with depth 2
    do_reset(32'h3000, 8'd2);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b1000, 16'(k), 1'b0, 1'b0);
      drain();
    end
    chk("wrap_count", 32'(seen.size()), 32'd3);
    if (seen.size() >= 3) begin
      chk("wrap_addr0", seen[0].addr, 32'h3000);
      chk("wrap_addr1", seen[1].addr, 32'h3004);
      chk("wrap_addr2", seen[2].addr, 32'h3000);
    end

    // async reset while stalled in WRITE
    do_reset(32'h5000, 8'd4);
    cyc(4'b0001, 16'h0055, 1'b0, 1'b0);
    cyc(4'b0000, 16'h0000, 1'b1, 1'b0);
    chk("pre_rst_write", 32'(bus.mem_write), 32'd1);
    #1 rst = 1'b1;
    #1 chk("async_rst_write", 32'(bus.mem_write), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) cyc(4'b0000, 16'h0000, 1'b0, 1'b0);
    chk("post_rst_count", 32'(seen.size()), 32'd0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    // pulse on the acceptance cycle is recorded, not dropped
    do_reset(32'h4000, 8'd4);
    cyc(4'b0010, 16'h000A, 1'b0, 1'b0);
    cyc(4'b0000, 16'h0000, 1'b0, 1'b0);
    cyc(4'b0010, 16'h000B, 1'b0, 1'b0);
    drain();
    chk("race_ovf", 32'(bus.ovf), 32'h0);
    chk("race_count", 32'(seen.size()), 32'd2);
    if (seen.size() >= 2) begin
      chk("race_data0", seen[0].data, 32'h4000_000A);
      chk("race_addr0", seen[0].addr, 32'h4000);
      chk("race_data1", seen[1].data, 32'h4000_000B);
      chk("race_addr1", seen[1].addr, 32'h4004);
    end

    // random traffic against the model
    for (int ep = 0; ep < 6; ep++) begin
      logic [7:0] d;
      logic [3:0] h;
      d = (ep == 0) ? 8'd0 : (ep == 1) ? 8'd1 : 8'($urandom_range(2, 9));
      do_reset($urandom & 32'hFFFF_FFFC, d);
      for (int n = 0; n < 300; n++) begin
        for (int b = 0; b < 4; b++) h[b] = ($urandom_range(0, 3) == 0);
        cyc(h, 16'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 15) == 0);
      end
      drain();
      chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
